// File: rtl/vsa_dmem.sv
// vsa_dmem: 32x5 data memory with a 2-entry write-through queue and write status.
module vsa_dmem #(
  parameter int AW     = 5,
  parameter int DW     = 5,
  parameter int QDEPTH = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          wr,
  output logic [DW-1:0] rdata,
  output logic          wq_valid,
  output logic [AW-1:0] wq_addr,
  output logic [DW-1:0] wq_data,
  input  logic          wq_ready,
  output logic          wq_full,
  output logic          overflow,
  output logic [7:0]    wr_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t        r_state, w_next;
  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_qa [QDEPTH];
  logic [DW-1:0] r_qd [QDEPTH];
  logic          r_rp, r_wp, r_ovf;
  logic [7:0]    r_cnt;
  logic          w_pop, w_acc;
  assign rdata    = r_mem[addr];
  assign wq_valid = r_state != EMPTY;
  assign wq_full  = r_state == FULL;
  assign wq_addr  = r_qa[r_rp];
  assign wq_data  = r_qd[r_rp];
  assign overflow = r_ovf;
  assign wr_count = r_cnt;
  assign w_pop    = wq_valid & wq_ready;
  // a write is queued unless the queue is full and nothing leaves this cycle
  assign w_acc    = wr & (r_state != FULL | w_pop);
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   w_next = wr ? ONE : EMPTY;
      ONE:     w_next = (wr & !w_pop) ? FULL : (w_pop & !wr) ? EMPTY : ONE;
      FULL:    w_next = (w_pop & !wr) ? ONE : FULL;
      default: w_next = EMPTY;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_rp    <= 1'b0;
      r_wp    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= 8'd0;
      for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_next;
      r_rp    <= r_rp ^ w_pop;
      r_wp    <= r_wp ^ w_acc;
      r_ovf   <= r_ovf | (wr & !w_acc);
      r_cnt   <= r_cnt + {7'd0, wr & (r_cnt != 8'hFF)};
      if (wr) r_mem[addr] <= wdata;
    end
  end
  always_ff @(posedge clock) begin
    if (w_acc) begin
      r_qa[r_wp] <= addr;
      r_qd[r_wp] <= wdata;
    end
  end
endmodule

// File: tb/tb_vsa_dmem.sv
// tb_vsa_dmem: randomized scoreboard bench for vsa_dmem against a queue-based reference model.
module tb_vsa_dmem;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] addr = '0, wdata = '0;
  logic       wr = 1'b0, wq_ready = 1'b0;
  logic [4:0] rdata, wq_addr, wq_data;
  logic       wq_valid, wq_full, overflow;
  logic [7:0] wr_count;

  vsa_dmem dut (
    .clock(clock), .reset_n(reset_n), .addr(addr), .wdata(wdata), .wr(wr),
    .rdata(rdata), .wq_valid(wq_valid), .wq_addr(wq_addr), .wq_data(wq_data),
    .wq_ready(wq_ready), .wq_full(wq_full), .overflow(overflow), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] a; logic [4:0] d; } ent_t;
  ent_t       exp_q[$];
  logic [4:0] m_mem [32];
  int         m_occ, m_cnt;
  logic       m_ovf;
  int         tests = 0, fails = 0;
  bit         started = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // reference model: memory array, occupancy counter and expected queue contents
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_occ = 0; m_cnt = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      bit pop, acc;
      pop = (m_occ > 0) && wq_ready;
      acc = wr && (m_occ < 2 || pop);
      if (wr) begin
        m_mem[addr] = wdata;
        if (m_cnt < 255) m_cnt++;
      end
      if (acc) exp_q.push_back('{a: addr, d: wdata});
      else if (wr) m_ovf = 1;
      m_occ = m_occ + int'(acc) - int'(pop);
    end
  end

  // monitor: compares outputs and pops the scoreboard on each handshake
  always @(negedge clock) begin
    if (reset_n && started) begin
      chk("rdata", rdata, m_mem[addr]);
      chk("wq_valid", wq_valid, m_occ > 0);
      chk("wq_full", wq_full, m_occ == 2);
      chk("overflow", overflow, m_ovf);
      chk("wr_count", wr_count, m_cnt);
      if (wq_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL head_unexpected: got %0h/%0h expected empty queue", wq_addr, wq_data);
        end else begin
          chk("wq_addr", wq_addr, exp_q[0].a);
          chk("wq_data", wq_data, exp_q[0].d);
          if (wq_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic [4:0] a, input logic [4:0] d, input logic r);
    @(posedge clock); #1;
    wr = w; addr = a; wdata = d; wq_ready = r;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 0; wr = 0; wq_ready = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
  endtask

  initial begin
    do_reset();
    started = 1;
    for (int a = 0; a < 32; a++) cyc(0, 5'(a), 0, 0);
    cyc(1, 7, 5'h13, 1);
    cyc(0, 7, 0, 1);
    cyc(0, 7, 0, 1);
    cyc(1, 3, 5'h01, 0);
    cyc(1, 4, 5'h02, 0);
    cyc(0, 3, 0, 0);
    cyc(0, 4, 0, 0);
    cyc(1, 9, 5'h1F, 0);
    cyc(0, 9, 0, 0);
    repeat (4) cyc(0, 9, 0, 1);
    do_reset();
    cyc(1, 3, 5'h01, 0);
    cyc(1, 4, 5'h02, 0);
    cyc(1, 5, 5'h03, 1);
    repeat (3) cyc(0, 5, 0, 1);
    cyc(1, 3, 5'h01, 0);
    cyc(1, 4, 5'h02, 0);
    cyc(0, 3, 0, 0);
    @(posedge clock); #2;
    reset_n = 0;
    #1;
    chk("rst_wq_valid", wq_valid, 0);
    chk("rst_mem3", rdata, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wq_full", wq_full, 0);
    #1 reset_n = 1;
    for (int i = 0; i < 300; i++) cyc(1, 5'($urandom), 5'($urandom), 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 2) == 0, 5'($urandom), 5'($urandom), $urandom_range(0, 2) != 0);
    repeat (4) cyc(0, 0, 0, 1);
    @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
